// File: rtl/bellman_scheduler.sv
// Sequencer for the Bellman-Ford engine: buffers adjacency updates, applies them while the
// engine is frozen, then launches a run. Optional source rotation: BELLMAN_SCHED_ROTATE_EN.
module bellman_scheduler #(
  parameter int NODES      = 8,
  parameter int PRED_W     = 3,
  parameter int WEIGHT_W   = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       upd_valid,
  output logic                       upd_ready,
  input  logic [PRED_W-1:0]          upd_row,
  input  logic [PRED_W-1:0]          upd_col,
  input  logic signed [WEIGHT_W-1:0] upd_weight,
  output logic                       adj_we,
  output logic [PRED_W-1:0]          adj_row,
  output logic [PRED_W-1:0]          adj_col,
  output logic signed [WEIGHT_W-1:0] adj_wdata,
  input  logic [PRED_W-1:0]          src_cfg,
  output logic                       bellman_reset,
  output logic [PRED_W-1:0]          src,
  input  logic                       bellman_done,
  output logic                       result_valid,
  output logic [15:0]                run_count,
  output logic                       busy,
  output logic                       timeout_err
);

  // FIFO_DEPTH must be a power of two >= 2 so the pointers wrap naturally.
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]       DEPTH_C    = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]       LAST_POP   = (AW+1)'(FIFO_DEPTH - 1);
  localparam logic [AW:0]       ONE_C      = (AW+1)'(1);
  localparam logic [TW-1:0]     TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [PRED_W-1:0] LAST_NODE  = PRED_W'(NODES - 1);

  typedef enum logic [2:0] {IDLE, DRAIN, START, RUN, REPORT} state_t;

  state_t state, next_state;

  logic [PRED_W-1:0]          fifo_row [FIFO_DEPTH];
  logic [PRED_W-1:0]          fifo_col [FIFO_DEPTH];
  logic signed [WEIGHT_W-1:0] fifo_wt  [FIFO_DEPTH];
  logic [AW-1:0]              wr_ptr, rd_ptr;
  logic [AW:0]                count, pops;
  logic [TW-1:0]              timer;
  logic                       dirty;
  logic                       push, pop, timeout_hit;

  assign upd_ready    = (count < DEPTH_C) && !reset;
  assign push         = upd_valid && upd_ready;
  assign pop          = (state == DRAIN) && (count != '0);
  assign timeout_hit  = (state == RUN) && (next_state == IDLE);
  assign result_valid = (state == REPORT);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_row[wr_ptr] <= upd_row;
      fifo_col[wr_ptr] <= upd_col;
      fifo_wt[wr_ptr]  <= upd_weight;
    end
  end

  always_comb begin
    next_state = state;
    adj_we     = 1'b0;
    adj_row    = '0;
    adj_col    = '0;
    adj_wdata  = '0;
    case (state)
      IDLE: begin
        if (count != '0)
          next_state = DRAIN;
        else if (dirty)
          next_state = START;
      end
      DRAIN: begin
        if (pop) begin
          adj_we    = 1'b1;
          adj_row   = fifo_row[rd_ptr];
          adj_col   = fifo_col[rd_ptr];
          adj_wdata = fifo_wt[rd_ptr];
        end
        // Leave when the buffer empties or after a full buffer's worth of pops.
        if (!pop || ((count == ONE_C) && !push) || (pops == LAST_POP))
          next_state = START;
      end
      START:   next_state = RUN;
      RUN: begin
        if ((timer != '0) && bellman_done)
          next_state = REPORT;
        else if (timer == TIMER_LAST)
          next_state = IDLE;
      end
      REPORT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      bellman_reset <= 1'b1;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      pops          <= '0;
      dirty         <= 1'b0;
      timer         <= '0;
      src           <= '0;
      run_count     <= '0;
      timeout_err   <= 1'b0;
    end else begin
      state         <= next_state;
      busy          <= (next_state != IDLE);
      bellman_reset <= (next_state != RUN);
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (state == IDLE)
        pops <= '0;
      else if (pop)
        pops <= pops + 1'b1;
      // A timed-out run marks the matrix dirty so it is rerun automatically.
      if (state == START)
        dirty <= 1'b0;
      else if (pop || timeout_hit)
        dirty <= 1'b1;
      if (timeout_hit)
        timeout_err <= 1'b1;
      if (state == START)
        timer <= '0;
      else if (state == RUN)
        timer <= timer + 1'b1;
      if (state == REPORT)
        run_count <= run_count + 16'd1;
`ifdef BELLMAN_SCHED_ROTATE_EN
      if (state == REPORT)
        src <= (src == LAST_NODE) ? '0 : src + 1'b1;
`else
      if (state == START)
        src <= src_cfg;
`endif
    end
  end

`ifdef BELLMAN_SCHED_ROTATE_EN
  logic unused_cfg;
  assign unused_cfg = ^src_cfg;
`endif

endmodule

// File: doc/bellman_scheduler.md
# bellman_scheduler

Sequencer that owns the Bellman-Ford arbitrage engine and its adjacency-matrix write port. It buffers incoming edge-weight updates from the market-data path and applies them only while the engine is held in reset. It then launches a relaxation run from a chosen source vertex and reports completion. It sits between the rate-update feed and the Bellman engine; downstream cycle-detection logic consumes `result_valid`.

## Interface
- `NODES`, 8: vertex count; `src` ranges 0..NODES-1
- `PRED_W`, 3: vertex index width (≥ clog2(NODES))
- `WEIGHT_W`, 32: signed edge-weight width
- `FIFO_DEPTH`, 4: update buffer entries (power of 2)
- `TIMEOUT`, 4096: max RUN cycles before abort
- `clk  in  1  clock`
- `reset  in  1  asynchronous, active-high reset`
- `upd_valid  in  1  update offered`
- `upd_ready  out  1  update accepted when valid&&ready`
- `upd_row, upd_col  in  PRED_W  edge source/destination`
- `upd_weight  in  WEIGHT_W  signed new weight (0 = no edge)`
- `adj_we  out  1  adjacency write strobe`
- `adj_row, adj_col  out  PRED_W  write address`
- `adj_wdata  out  WEIGHT_W  write data`
- `src_cfg  in  PRED_W  fixed source (see Configuration)`
- `bellman_reset  out  1  engine synchronous reset`
- `src  out  PRED_W  engine source vertex`
- `bellman_done  in  1  engine finished (sticky until bellman_reset)`
- `result_valid  out  1  one-cycle pulse per completed run`
- `run_count  out  16  completed runs, wraps`
- `busy  out  1  state != IDLE`
- `timeout_err  out  1  sticky, cleared only by reset`

## Operation
- States: IDLE, DRAIN, START, RUN, REPORT.
- IDLE: FIFO non-empty → DRAIN; else `dirty` → START; else stay.
- DRAIN:
  - Pop one entry per cycle. `adj_we`=1 with `adj_row`/`adj_col`/`adj_wdata` driven combinationally from the FIFO head. Set `dirty`.
  - Leave for START when the FIFO becomes empty, or after FIFO_DEPTH pops in this visit (anti-starvation), whichever is first.
- START: latch `src`, clear `dirty`. Exactly one cycle, then → RUN.
- RUN:
  - Clear the timer on entry, increment it each cycle.
  - Ignore `bellman_done` in the first RUN cycle. Thereafter `bellman_done`=1 → REPORT.
  - If the timer reaches TIMEOUT first: set `timeout_err`, set `dirty`, → IDLE. This forces a rerun.
- REPORT: `result_valid`=1, `run_count`+1, advance source per Configuration, → IDLE.
- `bellman_reset` is registered: it is 1 whenever the next state ≠ RUN. The engine therefore runs only in RUN and is frozen (vertmat retained) otherwise. Adjacency writes never overlap a run.
- FIFO:
  - `upd_ready` = (count < FIFO_DEPTH) && !reset.
  - Pushes are accepted in any state, including RUN.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap mod FIFO_DEPTH. Entries leave in arrival order.
- Duplicate (row, col) updates are all written; the last one wins.
- `adj_we`=0 outside DRAIN.
- Reset values:
  - State IDLE; FIFO empty; `dirty`=0.
  - `bellman_reset`=1; `src`=0; `run_count`=0.
  - `upd_ready`, `adj_we`, `result_valid`, `busy`, `timeout_err` = 0.
  - `adj_*` address/data = 0.
- Reset asserted mid-run: the engine is immediately held (`bellman_reset`=1) and buffered updates are discarded.

## Timing
- Update accepted at edge ending cycle t, idle engine: IDLE in t+1, `adj_we`=1 in t+2, START in t+3, `bellman_reset`=0 from t+4.
- N queued updates (N ≤ FIFO_DEPTH) drain in N consecutive cycles.
- `bellman_done` seen high in RUN cycle r → `result_valid`=1 in r+1. `run_count` and `src` update at the end of r+1. `bellman_reset` rises at the start of r+1.
- Timeout: `timeout_err` rises in the cycle after the TIMEOUT-th RUN cycle.
- `busy` is registered alongside state.

## Configuration
- `BELLMAN_SCHED_ROTATE_EN` defined: `src` starts at 0 and increments after each REPORT, wrapping NODES-1 → 0. `src_cfg` is ignored. A timed-out run keeps its `src` for the retry.
- Undefined: `src` ← `src_cfg` in every START cycle. No rotation.

## Test plan
- Reset: hold `reset`=1 mid-activity → `bellman_reset`=1, `adj_we`=0, `run_count`=0, `upd_ready`=0. Release → `upd_ready`=1, `busy`=0.
- Single update (2,5,−7) at t → `adj_we`=1 at t+2 with row 2, col 5, data −7. `bellman_reset`=0 from t+4. Model done after 20 cycles → one `result_valid` pulse, `run_count`=1.
- During RUN push 5 updates → `upd_ready`=0 after the 4th. No `adj_we` until REPORT. Then 4 consecutive writes in order, START, the 5th entry drains in the next visit, and 2 further runs follow.
- Done never asserted, TIMEOUT=64 → `timeout_err`=1 after 64 RUN cycles, `bellman_reset`=1, then automatic rerun. Rerun completes → `timeout_err` stays 1, `run_count`=1.
- Rotate enabled, NODES=8, 9 runs → `src` sequence 0,1,…,7,0.
- Rotate disabled, `src_cfg`=5 → every run has `src`=5.
